// File: rtl/z80_ram_arbiter.sv
// z80_ram_arbiter: shares one single-port 64Kx8 RAM between the gate-level Z80 bus and a host loader/debug port.
// Latency: a Z80 write is committed 1 eclk after its detection; a host op acks 2 eclk after acceptance.
// Backpressure: h_req is held until h_ack; the host waits while the Z80 uses memory (the Z80 always wins).
//
// Ports:
//   eclk, erst                    emulation clock (rising edge), asynchronous active-high reset
//   zclk, z_mreq_n, z_rfsh_n,     Z80 pad clock and memory/refresh/write strobes
//   z_wr_n, z_ab, z_dout, z_din   Z80 address, write data, read data (z_din = ram_dout)
//   h_req, h_we, h_addr, h_wdata  host request (held until ack), direction, address, write data
//   h_ack, h_rdata, h_wait        1-cycle ack, read data (held until next read ack), saturating wait count
//   ram_a, ram_din, ram_wr,       RAM address, write data, 1-cycle write strobe,
//   ram_dout                      RAM read data (1-cycle synchronous read)
//
// Option: define Z80ARB_RFSH_STEAL_EN to let the host use the RAM during Z80 refresh cycles.
module z80_ram_arbiter #(
   parameter int AW  = 16,
   parameter int DW  = 8,
   parameter int WCW = 16
) (
   input  logic           eclk,
   input  logic           erst,
   input  logic           zclk,
   input  logic           z_mreq_n,
   input  logic           z_rfsh_n,
   input  logic           z_wr_n,
   input  logic [AW-1:0]  z_ab,
   input  logic [DW-1:0]  z_dout,
   output logic [DW-1:0]  z_din,
   input  logic           h_req,
   input  logic           h_we,
   input  logic [AW-1:0]  h_addr,
   input  logic [DW-1:0]  h_wdata,
   output logic           h_ack,
   output logic [DW-1:0]  h_rdata,
   output logic [WCW-1:0] h_wait,
   output logic [AW-1:0]  ram_a,
   output logic [DW-1:0]  ram_din,
   output logic           ram_wr,
   input  logic [DW-1:0]  ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ZWR  = 3'd1,
      S_HWR  = 3'd2,
      S_HRD  = 3'd3,
      S_HACK = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic           r_last_zclk;
   logic           r_last_zw;
   logic           r_zpend;
   logic           r_h_we;
   logic [AW-1:0]  r_h_addr;
   logic [DW-1:0]  r_h_wdata;
   logic [DW-1:0]  r_h_rdata;
   logic [WCW-1:0] r_h_wait;

   logic           w_zrise;
   logic           w_zw;
   logic           w_zev;
   logic           w_zbusy;
   logic           w_idle;
   logic           w_zgo;
   logic           w_accept;
   logic           w_h_inflight;

   // One write event per Z80 write cycle: only the first zclk rise that sees
   // the write strobes active counts, later rises of the same cycle do not.
   assign w_zrise = zclk & ~r_last_zclk;
   assign w_zw    = ~z_mreq_n & ~z_wr_n;
   assign w_zev   = w_zrise & w_zw & ~r_last_zw;

`ifdef Z80ARB_RFSH_STEAL_EN
   // During refresh the Z80 drives mreq but never looks at RAM data.
   assign w_zbusy = ~z_mreq_n & z_rfsh_n;
`else
   logic w_unused_rfsh;
   assign w_unused_rfsh = z_rfsh_n;
   assign w_zbusy       = ~z_mreq_n;
`endif

   assign w_idle       = (r_state == S_IDLE);
   assign w_zgo        = w_idle & (w_zev | r_zpend);
   assign w_accept     = w_idle & ~(w_zev | r_zpend) & h_req & ~w_zbusy;
   assign w_h_inflight = (r_state == S_HWR) | (r_state == S_HRD) | (r_state == S_HACK);

   assign z_din  = ram_dout;
   assign h_wait = r_h_wait;

   always_ff @(posedge eclk or posedge erst) begin
      if (erst) begin
         r_state     <= S_IDLE;
         r_last_zclk <= 1'b0;
         r_last_zw   <= 1'b0;
         r_zpend     <= 1'b0;
         r_h_we      <= 1'b0;
         r_h_addr    <= '0;
         r_h_wdata   <= '0;
         r_h_rdata   <= '0;
         r_h_wait    <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_zclk <= zclk;
         if (w_zrise) begin
            r_last_zw <= w_zw;
         end
         // In IDLE the pending write is consumed now; a fresh event arriving
         // in that same cycle must survive for the next IDLE.
         r_zpend <= w_idle ? (r_zpend & w_zev) : (r_zpend | w_zev);
         if (w_accept) begin
            r_h_we    <= h_we;
            r_h_addr  <= h_addr;
            r_h_wdata <= h_wdata;
         end
         if ((r_state == S_HACK) && !r_h_we) begin
            r_h_rdata <= ram_dout;
         end
         // Cycles of an accepted op are not waiting time.
         if (w_accept) begin
            r_h_wait <= '0;
         end else if (h_req && !w_h_inflight && !(&r_h_wait)) begin
            r_h_wait <= r_h_wait + {{(WCW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ram_a       = z_ab;
      ram_din     = z_dout;
      ram_wr      = 1'b0;
      h_ack       = 1'b0;
      h_rdata     = r_h_rdata;
      case (r_state)
         S_IDLE: begin
            if (w_zgo) begin
               w_state_nxt = S_ZWR;
            end else if (w_accept) begin
               w_state_nxt = h_we ? S_HWR : S_HRD;
            end
         end
         S_ZWR: begin
            ram_wr      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_HWR: begin
            ram_wr      = 1'b1;
            ram_a       = r_h_addr;
            ram_din     = r_h_wdata;
            w_state_nxt = S_HACK;
         end
         S_HRD: begin
            ram_a       = r_h_addr;
            w_state_nxt = S_HACK;
         end
         S_HACK: begin
            // RAM already holds the host read data this cycle, so pass it
            // straight through to make it valid together with h_ack.
            h_ack = 1'b1;
            if (!r_h_we) begin
               h_rdata = ram_dout;
            end
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_z80_ram_arbiter.sv
module tb_z80_ram_arbiter;

   logic        eclk = 1'b0;
   logic        erst;
   logic        zclk;
   logic        z_mreq_n;
   logic        z_rfsh_n;
   logic        z_wr_n;
   logic [15:0] z_ab;
   logic [7:0]  z_dout;
   logic [7:0]  z_din;
   logic        h_req;
   logic        h_we;
   logic [15:0] h_addr;
   logic [7:0]  h_wdata;
   logic        h_ack;
   logic [7:0]  h_rdata;
   logic [15:0] h_wait;
   logic [15:0] ram_a;
   logic [7:0]  ram_din;
   logic        ram_wr;
   logic [7:0]  ram_dout;

   int n_chk  = 0;
   int n_fail = 0;

   z80_ram_arbiter dut (
      .eclk(eclk), .erst(erst), .zclk(zclk),
      .z_mreq_n(z_mreq_n), .z_rfsh_n(z_rfsh_n), .z_wr_n(z_wr_n),
      .z_ab(z_ab), .z_dout(z_dout), .z_din(z_din),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_ack(h_ack), .h_rdata(h_rdata), .h_wait(h_wait),
      .ram_a(ram_a), .ram_din(ram_din), .ram_wr(ram_wr), .ram_dout(ram_dout)
   );

   always #5 eclk = ~eclk;

   // Environment RAM: 64Kx8, synchronous read, read-before-write.
   logic [7:0] ram [0:65535];
   always @(posedge eclk) begin
      if (ram_wr) ram[ram_a] <= ram_din;
      ram_dout <= ram[ram_a];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Time-slot view: each memory operation occupies future cycles in a short
   // schedule; a cycle with nothing scheduled is free for a new decision.
   typedef struct packed {
      logic        v;
      logic        wr;
      logic        zsrc;
      logic        ack;
      logic        rd;
      logic [15:0] a;
      logic [7:0]  d;
   } op_t;

   op_t        sch0, sch1, sch2;
   logic [7:0] mmem [0:65535];
   logic [7:0] m_rdata;
   logic [15:0] m_wait;
   int         m_pend;
   bit         m_inflight, m_prev_zclk, m_in_wr;
   int         ack_cnt, wr_cnt;
   logic [15:0] last_wa;
   logic [7:0]  last_wd;

   always @(negedge eclk) begin : model
      op_t        cur;
      bit         rise, ev, zw, zbusy, acc;
      logic [7:0] exp_din;
      if (erst) begin
         chk("rst_ram_wr", ram_wr, 0);
         chk("rst_h_ack", h_ack, 0);
         chk("rst_h_rdata", h_rdata, 0);
         chk("rst_h_wait", h_wait, 0);
         sch0 = '0; sch1 = '0; sch2 = '0;
         m_rdata = 0; m_wait = 0; m_pend = 0;
         m_inflight = 0; m_prev_zclk = 0; m_in_wr = 0;
      end else begin
         cur = sch0;
         chk("ram_wr", ram_wr, cur.v & cur.wr);
         chk("ram_a", ram_a, (cur.v && !cur.zsrc && !cur.ack) ? cur.a : z_ab);
         if (cur.v && cur.wr) begin
            exp_din = cur.zsrc ? z_dout : cur.d;
            chk("ram_din", ram_din, exp_din);
            mmem[cur.zsrc ? z_ab : cur.a] = exp_din;
         end
         if (cur.v && cur.ack && cur.rd) m_rdata = mmem[cur.a];
         chk("h_ack", h_ack, cur.v & cur.ack);
         chk("h_rdata", h_rdata, m_rdata);
         chk("h_wait", h_wait, m_wait);
         // decisions taken at the end of this cycle
         zw   = !z_mreq_n && !z_wr_n;
         rise = zclk && !m_prev_zclk;
         ev   = rise && zw && !m_in_wr;
         if (rise) m_in_wr = zw;
         m_prev_zclk = zclk;
         if (ev) m_pend++;
`ifdef Z80ARB_RFSH_STEAL_EN
         zbusy = !z_mreq_n && z_rfsh_n;
`else
         zbusy = !z_mreq_n;
`endif
         acc = 0;
         if (!cur.v) begin
            if (m_pend > 0) begin
               m_pend--;
               sch1 = '0; sch1.v = 1; sch1.wr = 1; sch1.zsrc = 1;
            end else if (h_req && !zbusy) begin
               acc = 1;
               sch1 = '0; sch1.v = 1; sch1.wr = h_we; sch1.a = h_addr; sch1.d = h_wdata;
               sch2 = '0; sch2.v = 1; sch2.ack = 1; sch2.rd = !h_we; sch2.a = h_addr;
            end
         end
         if (acc) m_wait = 0;
         else if (h_req && !m_inflight && m_wait != 16'hFFFF) m_wait++;
         if (acc) m_inflight = 1;
         if (cur.v && cur.ack) m_inflight = 0;
         sch0 = sch1; sch1 = sch2; sch2 = '0;
      end
   end

   always @(negedge eclk) begin
      if (!erst) begin
         if (h_ack) ack_cnt++;
         if (ram_wr) begin wr_cnt++; last_wa = ram_a; last_wd = ram_din; end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge eclk); #1; end
   endtask

   task automatic host_start(input bit we, input logic [15:0] a, input logic [7:0] d);
      h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
   endtask

   // Returns the number of cycles after the request cycle until h_ack (0 = none).
   task automatic wait_ack(input int maxc, output int n);
      bit done;
      n = 0; done = 0;
      for (int i = 1; i <= maxc && !done; i++) begin
         @(posedge eclk); #1;
         if (h_ack) begin n = i; h_req = 1'b0; done = 1; end
      end
   endtask

   task automatic zpulse(input int n);
      for (int i = 0; i < n; i++) begin
         zclk = 1'b1; cyc(2);
         zclk = 1'b0; cyc(2);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      erst = 1'b1; zclk = 0; z_mreq_n = 1; z_rfsh_n = 1; z_wr_n = 1;
      z_ab = 16'h0000; z_dout = 8'h00;
      h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
      ack_cnt = 0; wr_cnt = 0; last_wa = 0; last_wd = 0;
      for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; mmem[i] = 8'h00; end
      ram[16'h0100] = 8'h3C; mmem[16'h0100] = 8'h3C;

      // reset state
      cyc(3);
      chk("reset_ram_wr", ram_wr, 0);
      chk("reset_h_ack", h_ack, 0);
      chk("reset_h_rdata", h_rdata, 8'h00);
      chk("reset_h_wait", h_wait, 16'h0000);
      erst = 1'b0;
      cyc(2);

      // Z80 write detect: one pulse for three zclk rises
      z_ab = 16'h1234; z_dout = 8'hA5; z_mreq_n = 0; z_wr_n = 0;
      wr_cnt = 0;
      cyc(1);
      zpulse(3);
      chk("zwr_pulses", wr_cnt, 1);
      chk("zwr_addr", last_wa, 16'h1234);
      chk("zwr_data", last_wd, 8'hA5);
      chk("zwr_ram", ram[16'h1234], 8'hA5);
      z_mreq_n = 1; z_wr_n = 1;
      zpulse(1);

      // host read with Z80 idle
      host_start(0, 16'h0100, 8'h00);
      wait_ack(10, n);
      chk("hrd_latency", n, 2);
      chk("hrd_data", h_rdata, 8'h3C);
      cyc(2);
      chk("hrd_data_held", h_rdata, 8'h3C);

      // host write blocked by 50 cycles of Z80 memory use
      z_mreq_n = 0; z_rfsh_n = 1; z_wr_n = 1; z_ab = 16'h4444;
      cyc(1);
      host_start(1, 16'h0200, 8'h77);
      cyc(50);
      chk("hwr_no_ack_while_busy", ack_cnt, 1);
      chk("hwr_wait_50", h_wait, 16'd50);
      z_mreq_n = 1;
      wait_ack(10, n);
      chk("hwr_latency_after_release", n, 2);
      chk("hwr_ram", ram[16'h0200], 8'h77);
      cyc(2);

      // simultaneous Z80 write event and host write: Z80 first
      ack_cnt = 0; wr_cnt = 0;
      z_ab = 16'h0400; z_dout = 8'h22; z_mreq_n = 0; z_wr_n = 0; zclk = 1;
      host_start(1, 16'h0300, 8'h11);
      cyc(2);
      z_mreq_n = 1; z_wr_n = 1; zclk = 0;
      wait_ack(10, n);
      chk("both_host_latency", n, 2);
      cyc(3);
      chk("both_one_ack", ack_cnt, 1);
      chk("both_two_writes", wr_cnt, 2);
      chk("both_ram_z", ram[16'h0400], 8'h22);
      chk("both_ram_h", ram[16'h0300], 8'h11);

      // host read during Z80 refresh
      z_mreq_n = 0; z_rfsh_n = 0; z_wr_n = 1; z_ab = 16'h0055;
      cyc(1);
      host_start(0, 16'h0100, 8'h00);
`ifdef Z80ARB_RFSH_STEAL_EN
      wait_ack(10, n);
      chk("rfsh_steal_latency", n, 2);
`else
      wait_ack(10, n);
      chk("rfsh_no_ack", n, 0);
      z_mreq_n = 1; z_rfsh_n = 1;
      wait_ack(10, n);
      chk("rfsh_ack_after_release", n, 2);
`endif
      chk("rfsh_data", h_rdata, 8'h3C);
      z_mreq_n = 1; z_rfsh_n = 1;
      cyc(2);

      // reset in the middle of a host read
      ram[16'h0500] = 8'h9E; mmem[16'h0500] = 8'h9E;
      z_ab = 16'hBEEF;
      ack_cnt = 0; wr_cnt = 0;
      host_start(0, 16'h0500, 8'h00);
      @(posedge eclk); #3;
      erst = 1'b1;
      #1;
      chk("abort_h_ack", h_ack, 0);
      chk("abort_ram_wr", ram_wr, 0);
      chk("abort_h_rdata", h_rdata, 8'h00);
      chk("abort_h_wait", h_wait, 16'h0000);
      chk("abort_ram_a", ram_a, 16'hBEEF);
      h_req = 1'b0;
      cyc(2);
      erst = 1'b0;
      cyc(4);
      chk("abort_no_ack", ack_cnt, 0);
      chk("abort_no_wr", wr_cnt, 0);
      host_start(0, 16'h0500, 8'h00);
      wait_ack(10, n);
      chk("post_reset_latency", n, 2);
      chk("post_reset_data", h_rdata, 8'h9E);
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
